// File: rtl/layer_seq_if.sv
// layer_seq_if: mat_mul stage bus (activation, layer select, done/flag handshake, result)
interface layer_seq_if #(parameter int N = 32, parameter int W = 6);
  logic [W-1:0][N-1:0] mm_act;
  logic [W-1:0][N-1:0] mm_out;
  logic [1:0]          mm_layer;
  logic                mm_done;
  logic                mm_flag;
  modport master (output mm_act, mm_layer, mm_done, input mm_flag, mm_out);
  modport slave  (input mm_act, mm_layer, mm_done, output mm_flag, mm_out);
endinterface

// File: rtl/layer_seq.sv
// layer_seq: runs LAYERS mat_mul passes over an activation register then argmaxes it; LAYER_SEQ_SAT_EN clamps captures to +/-2^15
module layer_seq #(
  parameter int N      = 32,
  parameter int W      = 6,
  parameter int LAYERS = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W-1:0][N-1:0]    x_in,
  layer_seq_if.master            mm,
  output logic                   busy,
  output logic [W-1:0][N-1:0]    logits,
  output logic [$clog2(W)-1:0]   class_out,
  output logic                   result_valid
);
  localparam int KW = $clog2(W);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [2:0] IDLE = 3'd0, COMPUTE = 3'd1, RELEASE = 3'd2, ARGMAX = 3'd3, DONE = 3'd4;
`ifdef LAYER_SEQ_SAT_EN
  localparam logic signed [N-1:0] SAT_HI = N'(32'sd32767);
  localparam logic signed [N-1:0] SAT_LO = N'(-32'sd32768);
`endif
  logic [2:0]          state_q, state_d;
  logic [W-1:0][N-1:0] act_q, act_d, cap;
  logic [1:0]          layer_q, layer_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [KW-1:0]       k_q, k_d, best_idx_q, best_idx_d;
  logic [N-1:0]        best_val_q, best_val_d;
  logic                settled;
  assign settled = settle_q == SW'(SETTLE - 1);
  always_comb begin
    for (int i = 0; i < W; i++)
`ifdef LAYER_SEQ_SAT_EN
      cap[i] = $signed(mm.mm_out[i]) > SAT_HI ? SAT_HI : $signed(mm.mm_out[i]) < SAT_LO ? SAT_LO : mm.mm_out[i];
`else
      cap[i] = mm.mm_out[i];
`endif
  end
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    layer_d    = layer_q;
    settle_d   = settle_q;
    k_d        = k_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    case (state_q)
      IDLE: if (start) begin
        act_d    = x_in;
        layer_d  = '0;
        settle_d = '0;
        state_d  = COMPUTE;
      end
      COMPUTE: begin
        settle_d = settled ? settle_q : settle_q + SW'(1);
        if (settled && mm.mm_flag) begin
          act_d   = cap;
          state_d = RELEASE;
        end
      end
      RELEASE: if (layer_q == 2'(LAYERS - 1)) begin
        k_d     = '0;
        state_d = ARGMAX;
      end else begin
        layer_d  = layer_q + 2'd1;
        settle_d = '0;
        state_d  = COMPUTE;
      end
      ARGMAX: begin
        if (k_q == '0 || $signed(act_q[k_q]) > $signed(best_val_q)) begin
          best_val_d = act_q[k_q];
          best_idx_d = k_q;
        end
        k_d     = k_q + KW'(1);
        state_d = k_q == KW'(W - 1) ? DONE : ARGMAX;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      act_q      <= '0;
      layer_q    <= '0;
      settle_q   <= '0;
      k_q        <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      layer_q    <= layer_d;
      settle_q   <= settle_d;
      k_q        <= k_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end
  assign mm.mm_act     = act_q;
  assign mm.mm_layer   = layer_q;
  assign mm.mm_done    = state_q != COMPUTE;
  assign busy          = state_q != IDLE;
  assign logits        = act_q;
  assign class_out     = best_idx_q;
  assign result_valid  = state_q == DONE;
endmodule

// File: doc/layer_seq.md
# layer_seq

Inference controller wrapped around the combinational `mat_mul` stage.
- **Upstream role:** latches an input feature vector, then drives `mat_mul` with the current activation vector, the layer index and the active-low compute enable.
- **Downstream role:** captures the `mat_mul` result back into the activation register, once per layer, for `LAYERS` layers.
- **Final stage:** after the last layer, scans the logits serially and reports the argmax class with a one-cycle valid pulse.

## Interface
- `N`, 32: data word width, signed Q(N-12).11 fixed point.
- `W`, 6: vector length; matrix is W×W.
- `LAYERS`, 4: layers per inference, at most 4.
- `SETTLE`, 2: minimum COMPUTE cycles per layer, at least 1. Multicycle budget for the `mat_mul` combinational path.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an inference; sampled only in IDLE.
- `x_in` in N×W: input vector, signed; latched on an accepted `start`.
- `mm_act` out N×W: activation vector to `mat_mul` `mat2`.
- `mm_layer` out 2: layer index to `mat_mul` `layer` and to the external weight/bias select.
- `mm_done` out 1: to `mat_mul` `done`; 0 = compute, 1 = hold.
- `mm_flag` in 1: from `mat_mul` `flag`.
- `mm_out` in N×W: from `mat_mul` `out`.
- `busy` out 1: high in every state except IDLE.
- `logits` out N×W: activation register; after DONE it holds the final-layer values.
- `class_out` out $clog2(W): argmax index.
- `result_valid` out 1: one-cycle pulse in DONE.

## Operation
- **Reset values:** state IDLE; `act`, `layer_cnt`, settle counter, `best_idx` and `best_val` all 0; `mm_done`=1; `busy`=0; `result_valid`=0; `class_out`=0.
- **States:** IDLE, COMPUTE, RELEASE, ARGMAX, DONE.
- **IDLE:** `mm_done`=1.
  - `start`=1: `act`←`x_in`, `layer_cnt`←0, settle counter←0, go to COMPUTE.
- **COMPUTE:** `mm_done`=0, `mm_layer`=`layer_cnt`; settle counter increments, saturating at SETTLE-1.
  - Capture when settle counter = SETTLE-1 and `mm_flag`=1: `act`←`mm_out`, go to RELEASE.
  - Otherwise stay in COMPUTE; a low `mm_flag` stalls indefinitely.
- **RELEASE:** `mm_done`=1 for one cycle, so `mm_flag` drops between layers.
  - If `layer_cnt`=LAYERS-1: go to ARGMAX with `k`←0.
  - Else: `layer_cnt`++, settle counter←0, go to COMPUTE.
- **ARGMAX:** one element per cycle, k = 0..W-1.
  - k=0 loads `best_val`/`best_idx` unconditionally.
  - Later k replace the best only if `act[k]` > `best_val` (signed, strict). Ties resolve to the lowest index.
  - After k=W-1, go to DONE.
- **DONE:** `result_valid`=1, `class_out`=`best_idx`; go to IDLE next cycle. `class_out` and `logits` hold until the next accepted `start`.
- **Ignored start:** `start` is ignored in every state except IDLE, including DONE.
- **No write-back outside capture:** `act` is written only on the accepted `start` and on COMPUTE capture. `mm_act` is `act`.
- **Reset mid-operation:** returns to IDLE immediately with reset values. No `result_valid` is produced for the aborted run.

## Timing
- Accepted `start` in cycle 0; COMPUTE for layer 0 begins in cycle 1.
- Each layer takes SETTLE + 1 cycles with no stall (SETTLE COMPUTE + 1 RELEASE).
- `result_valid` asserts in cycle 1 + LAYERS·(SETTLE+1) + W. Defaults give cycle 19.
- Each `mm_flag`-low cycle at the capture point adds one cycle of latency.
- `start` may next be accepted in the cycle after DONE.

## Configuration
- `LAYER_SEQ_SAT_EN` defined: each captured `mm_out` element is clamped to [-(2^15), 2^15-1], i.e. ±16.0 in Q.11, before writing `act`.
- Undefined: `mm_out` is written unmodified. Wrap-around is the upstream's responsibility.

## Test plan
- **Reset:** `rst_n` low for 3 cycles → `busy`=0, `result_valid`=0, `class_out`=0, `logits` all 0, `mm_done`=1.
- **Nominal run:** identity weights (2048 on the diagonal), bias 0, `x_in`=[2048,-1024,4096,0,512,100], defaults.
  - Expect `logits`=[2048,0,4096,0,512,100] and `class_out`=2.
  - `result_valid` pulses in cycle 19 only; `mm_done` is 1 in cycles 3, 6, 9, 12.
- **Tie:** identity weights, `x_in` all 1000 → `class_out`=0.
- **Stall:** force `mm_flag`=0 for 5 cycles during layer 1 COMPUTE → `result_valid` in cycle 24; `act` is unchanged until capture.
- **Busy start / mid-run reset:**
  - `start` pulsed in cycles 5 and 19 → ignored.
  - Assert `rst_n`=0 in cycle 14 (ARGMAX) → IDLE next, no `result_valid`.
- **Saturation:** with `LAYER_SEQ_SAT_EN`, bias 40960 on row 0 → `logits[0]`=32767. Without the macro → 40960+`x_in[0]`-derived value, unclamped.
